// File: rtl/adder_share_arbiter_if.sv
// Handshake bundle between the requesters, the adder-share arbiter and the
// shared pipelined adder. The arbiter uses the slave view; the requesters plus
// adder wrapper together take the master view.
interface adder_share_arbiter_if #(
  parameter int WIDTH = 64,
  parameter int NREQ  = 4
);
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic [NREQ-1:0]       req_cin;
  logic [NREQ-1:0]       rsp_valid;
  logic [NREQ-1:0]       rsp_ready;
  logic [NREQ*WIDTH-1:0] rsp_sum;
  logic [NREQ-1:0]       rsp_cout;
  logic [WIDTH-1:0]      add_a;
  logic [WIDTH-1:0]      add_b;
  logic                  add_cin;
  logic [WIDTH-1:0]      add_sum;
  logic                  add_cout;

  modport slave (
    input  req_valid, req_a, req_b, req_cin, rsp_ready, add_sum, add_cout,
    output req_ready, rsp_valid, rsp_sum, rsp_cout, add_a, add_b, add_cin
  );

  modport master (
    output req_valid, req_a, req_b, req_cin, rsp_ready, add_sum, add_cout,
    input  req_ready, rsp_valid, rsp_sum, rsp_cout, add_a, add_b, add_cin
  );
endinterface

// File: rtl/adder_share_arbiter.sv
// Round-robin arbiter that shares one fixed-latency pipelined adder among
// NREQ requesters. Each issue is tagged with its requester index; the tag
// travels alongside the adder pipeline so the result lands in the right
// response slot, where it is held until that requester accepts it.
module adder_share_arbiter #(
  parameter int WIDTH = 64,
  parameter int NREQ  = 4,
  parameter int LAT   = 2
) (
  input logic                  clk,
  input logic                  rst,
  adder_share_arbiter_if.slave bus
);
  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PTR_W-1:0]      ptr;
  logic [NREQ-1:0]       busy;
  logic [NREQ-1:0]       eligible;
  logic [NREQ-1:0]       grant;
  logic [NREQ-1:0]       accept;
  logic [NREQ-1:0]       cap;
  logic [PTR_W-1:0]      gidx;
  logic                  hs;

  logic                  vld_p0;
  logic [PTR_W-1:0]      tag_p0;
  logic [WIDTH-1:0]      a_p0;
  logic [WIDTH-1:0]      b_p0;
  logic                  cin_p0;

  logic [LAT-1:0]        vld_pn;
  logic [PTR_W-1:0]      tag_pn [LAT];

  logic [NREQ-1:0]       rsp_vld;
  logic [NREQ*WIDTH-1:0] rsp_sum_q;
  logic [NREQ-1:0]       rsp_cout_q;

  // A requester is only eligible with no operation in flight and no result held.
  assign eligible = bus.req_valid & ~busy;
  assign accept   = rsp_vld & bus.rsp_ready;
  assign hs       = |grant;

  // Rotating priority search: the lowest offset from ptr wins, so iterating from
  // the far end and overwriting leaves the nearest eligible index as the grant.
  always_comb begin
    int               idx;
    logic [PTR_W-1:0] sel;
    grant = '0;
    gidx  = '0;
    idx   = 0;
    sel   = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      sel = PTR_W'(idx);
      if (eligible[sel]) begin
        grant      = '0;
        grant[sel] = 1'b1;
        gidx       = sel;
      end
    end
  end

  // Grant is suppressed while reset is asserted so nothing handshakes in reset.
  assign bus.req_ready = rst ? '0 : grant;

  // Stage p0: capture the granted operands into the adder input register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr    <= '0;
      busy   <= '0;
      vld_p0 <= 1'b0;
      a_p0   <= '0;
      b_p0   <= '0;
      cin_p0 <= 1'b0;
    end else begin
      busy   <= (busy & ~accept) | grant;
      vld_p0 <= hs;
      if (hs) begin
        ptr    <= (gidx == PTR_W'(NREQ - 1)) ? '0 : gidx + 1'b1;
        a_p0   <= bus.req_a[gidx*WIDTH +: WIDTH];
        b_p0   <= bus.req_b[gidx*WIDTH +: WIDTH];
        cin_p0 <= bus.req_cin[gidx];
      end
    end
  end

  // Tag register alongside p0 operands; data only, so no reset.
  always_ff @(posedge clk) begin
    tag_p0 <= gidx;
  end

  assign bus.add_a   = a_p0;
  assign bus.add_b   = b_p0;
  assign bus.add_cin = cin_p0;

  // Stages p1..pLAT: tag valids shadow the adder latency, bubbles included.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pn <= '0;
    end else begin
      vld_pn[0] <= vld_p0;
      for (int i = 1; i < LAT; i++) vld_pn[i] <= vld_pn[i-1];
    end
  end

  // Tag values travel with their valids; stale tags are harmless when valid is 0.
  always_ff @(posedge clk) begin
    tag_pn[0] <= tag_p0;
    for (int i = 1; i < LAT; i++) tag_pn[i] <= tag_pn[i-1];
  end

  // Decode the emerging tag into the response slot that receives this sum.
  always_comb begin
    cap = '0;
    if (vld_pn[LAT-1]) cap[tag_pn[LAT-1]] = 1'b1;
  end

  // Response slots: capture on tag arrival, hold until the requester accepts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_vld    <= '0;
      rsp_sum_q  <= '0;
      rsp_cout_q <= '0;
    end else begin
      rsp_vld <= (rsp_vld & ~accept) | cap;
      for (int i = 0; i < NREQ; i++) begin
        if (cap[i]) begin
          rsp_sum_q[i*WIDTH +: WIDTH] <= bus.add_sum;
          rsp_cout_q[i]               <= bus.add_cout;
        end
      end
    end
  end

  assign bus.rsp_valid = rsp_vld;
  assign bus.rsp_sum   = rsp_sum_q;
  assign bus.rsp_cout  = rsp_cout_q;
endmodule
